// File: rtl/cve2_pkg.sv
// Shared definitions for the core's CSR slice: CSR numbers owned by the
// counter unit, hardware performance event ids and counter index bounds.
package cve2_pkg;

    // Subset of the CSR address map used by the counter/timer block.
    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT  = 12'h320,
        CSR_MHPMEVENT3     = 12'h323,
        CSR_MHPMEVENT12    = 12'h32C,
        CSR_MCYCLE         = 12'hB00,
        CSR_MINSTRET       = 12'hB02,
        CSR_MHPMCOUNTER3   = 12'hB03,
        CSR_MHPMCOUNTER12  = 12'hB0C,
        CSR_MCYCLEH        = 12'hB80,
        CSR_MINSTRETH      = 12'hB82,
        CSR_MHPMCOUNTER3H  = 12'hB83,
        CSR_MHPMCOUNTER12H = 12'hB8C,
        CSR_CYCLE          = 12'hC00,
        CSR_INSTRET        = 12'hC02,
        CSR_CYCLEH         = 12'hC80,
        CSR_INSTRETH       = 12'hC82
    } csr_num_e;

    // Bit positions inside the event pulse vector.
    typedef enum logic [3:0] {
        HPM_EV_LOAD         = 4'd0,
        HPM_EV_STORE        = 4'd1,
        HPM_EV_JUMP         = 4'd2,
        HPM_EV_BRANCH       = 4'd3,
        HPM_EV_BRANCH_TAKEN = 4'd4,
        HPM_EV_COMPRESSED   = 4'd5,
        HPM_EV_MUL_WAIT     = 4'd6,
        HPM_EV_DIV_WAIT     = 4'd7,
        HPM_EV_LD_WAIT      = 4'd8,
        HPM_EV_ST_WAIT      = 4'd9
    } hpm_event_e;

    localparam int unsigned HPM_FIRST_IDX = 32'd3;
    localparam int unsigned HPM_LAST_IDX  = 32'd12;

    // Writable bits of mcountinhibit: CY, IR and one bit per implemented
    // mhpmcounter; bit 1 (TM) is always 0.
    function automatic logic [31:0] hpm_inhibit_mask(input int unsigned num);
        return ((32'd1 << (num + 32'd3)) - 32'd1) & ~32'd2;
    endfunction

endpackage

// File: rtl/cve2_hpm_counter.sv
// One machine counter of configurable width. The low and high 32-bit halves
// are written independently; a write wins over that cycle's increment.
module cve2_hpm_counter import cve2_pkg::*; #(
    parameter int unsigned Width = 32'd64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [Width-1:0] count_r;
    logic [63:0]      value_s;
    logic [63:0]      next_s;
    logic             unused_s;

    // Zero-extend the implemented bits to the architectural 64 bits.
    always_comb begin
        value_s              = 64'd0;
        value_s[Width-1:0]   = count_r;
    end

    // Next value: a write replaces one half, otherwise a full-width +1 with carry.
    always_comb begin
        next_s = value_s;
        if (we_lo_i) begin
            next_s[31:0] = wdata_i;
        end else if (we_hi_i) begin
            next_s[63:32] = wdata_i;
        end else if (inc_i) begin
            next_s = value_s + 64'd1;
        end else begin
            next_s = value_s;
        end
    end

    // Counter state; truncation to Width gives the wrap to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= '0;
        end else begin
            count_r <= next_s[Width-1:0];
        end
    end

    assign value_o  = value_s;
    assign unused_s = ^next_s;

endmodule

// File: rtl/cve2_hpm_counter_unit_chk.sv
// Interface properties of the counter unit's CSR read/write port.
module cve2_hpm_counter_unit_chk (
    input logic        clk_i,
    input logic        rst_ni,
    input logic        csr_re_i,
    input logic        csr_we_i,
    input logic        csr_hit_i,
    input logic        csr_illegal_i,
    input logic [31:0] csr_rdata_i
);

    a_nohit_reads_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (csr_re_i && !csr_hit_i) |-> (csr_rdata_i == 32'd0));

    a_illegal_needs_hit_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
        csr_illegal_i |-> (csr_hit_i && csr_we_i));

endmodule

// File: rtl/cve2_hpm_counter_unit.sv
// Machine counter/timer CSRs: mcycle, minstret, mhpmcounter3..12 with their
// event selectors, and mcountinhibit. Slot index k equals the CSR number's
// low nibble (0 = cycle, 2 = instret, 3..12 = hpm); slot 1 is unused.
module cve2_hpm_counter_unit import cve2_pkg::*; #(
    parameter int unsigned MHPMCounterNum   = 32'd10,
    parameter int unsigned MHPMCounterWidth = 32'd40,
    parameter int unsigned NumEvents        = 32'd16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [11:0]          csr_addr_i,
    input  logic [31:0]          csr_wdata_i,
    input  logic                 csr_we_i,
    input  logic                 csr_re_i,
    output logic [31:0]          csr_rdata_o,
    output logic                 csr_hit_o,
    output logic                 csr_illegal_o,
    input  logic                 instr_ret_i,
    input  logic [NumEvents-1:0] events_i,
    input  logic                 debug_mode_i,
    input  logic                 dcsr_stopcount_i
);

    localparam int unsigned NumSlots    = HPM_LAST_IDX + 32'd1;
    localparam logic [31:0] InhibitMask = hpm_inhibit_mask(MHPMCounterNum);

    logic                 freeze_s;
    logic [31:0]          mcountinhibit_r;
    logic                 we_inhibit_s;
    logic [NumSlots-1:0]  inc_s;
    logic [NumSlots-1:0]  we_lo_s;
    logic [NumSlots-1:0]  we_hi_s;
    logic [NumSlots-1:0]  we_evt_s;
    logic [63:0]          cnt_val_s [NumSlots];
    logic [NumEvents-1:0] evt_val_s [NumSlots];
    logic [3:0]           slot_s;
    logic [31:0]          rdata_s;
    logic                 hit_s;
    logic                 illegal_s;
    logic                 unused_s;

    assign freeze_s = debug_mode_i & dcsr_stopcount_i;

    assign inc_s[0]     = ~mcountinhibit_r[0] & ~freeze_s;
    assign inc_s[1]     = 1'b0;
    assign inc_s[2]     = instr_ret_i & ~mcountinhibit_r[2] & ~freeze_s;
    assign cnt_val_s[1] = 64'd0;
    assign evt_val_s[0] = '0;
    assign evt_val_s[1] = '0;
    assign evt_val_s[2] = '0;

    cve2_hpm_counter #(.Width(32'd64)) u_mcycle (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (inc_s[0]),
        .we_lo_i (we_lo_s[0]),
        .we_hi_i (we_hi_s[0]),
        .wdata_i (csr_wdata_i),
        .value_o (cnt_val_s[0])
    );

    cve2_hpm_counter #(.Width(32'd64)) u_minstret (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (inc_s[2]),
        .we_lo_i (we_lo_s[2]),
        .we_hi_i (we_hi_s[2]),
        .wdata_i (csr_wdata_i),
        .value_o (cnt_val_s[2])
    );

    for (genvar k = HPM_FIRST_IDX; k <= HPM_LAST_IDX; k++) begin : g_hpm
        if (k <= HPM_FIRST_IDX - 32'd1 + MHPMCounterNum) begin : g_impl
            logic [NumEvents-1:0] event_r;

            // Event selector for this counter.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    event_r <= '0;
                end else if (we_evt_s[k]) begin
                    event_r <= csr_wdata_i[NumEvents-1:0];
                end
            end

            // Any selected event in the cycle counts once.
            assign inc_s[k]     = (|(events_i & event_r)) & ~mcountinhibit_r[k] & ~freeze_s;
            assign evt_val_s[k] = event_r;

            cve2_hpm_counter #(.Width(MHPMCounterWidth)) u_cnt (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .inc_i   (inc_s[k]),
                .we_lo_i (we_lo_s[k]),
                .we_hi_i (we_hi_s[k]),
                .wdata_i (csr_wdata_i),
                .value_o (cnt_val_s[k])
            );
        end else begin : g_unimpl
            assign inc_s[k]     = 1'b0;
            assign evt_val_s[k] = '0;
            assign cnt_val_s[k] = 64'd0;
        end
    end

    // Inhibit register; read-only-zero bits are masked on write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcountinhibit_r <= 32'd0;
        end else if (we_inhibit_s) begin
            mcountinhibit_r <= csr_wdata_i & InhibitMask;
        end
    end

    // Address decode, read mux and per-slot write strobes.
    always_comb begin
        slot_s       = csr_addr_i[3:0];
        rdata_s      = 32'd0;
        hit_s        = 1'b0;
        illegal_s    = 1'b0;
        we_inhibit_s = 1'b0;
        we_lo_s      = '0;
        we_hi_s      = '0;
        we_evt_s     = '0;
        if (csr_addr_i == CSR_MCOUNTINHIBIT) begin
            hit_s        = 1'b1;
            rdata_s      = mcountinhibit_r;
            we_inhibit_s = csr_we_i;
        end else if (csr_addr_i >= CSR_MHPMEVENT3 && csr_addr_i <= CSR_MHPMEVENT12) begin
            hit_s            = 1'b1;
            rdata_s          = 32'(evt_val_s[slot_s]);
            we_evt_s[slot_s] = csr_we_i;
        end else if (csr_addr_i == CSR_MCYCLE ||
                     (csr_addr_i >= CSR_MINSTRET && csr_addr_i <= CSR_MHPMCOUNTER12)) begin
            hit_s           = 1'b1;
            rdata_s         = cnt_val_s[slot_s][31:0];
            we_lo_s[slot_s] = csr_we_i;
        end else if (csr_addr_i == CSR_MCYCLEH ||
                     (csr_addr_i >= CSR_MINSTRETH && csr_addr_i <= CSR_MHPMCOUNTER12H)) begin
            hit_s           = 1'b1;
            rdata_s         = cnt_val_s[slot_s][63:32];
            we_hi_s[slot_s] = csr_we_i;
        end else if (csr_addr_i == CSR_CYCLE || csr_addr_i == CSR_INSTRET) begin
            hit_s     = 1'b1;
            rdata_s   = cnt_val_s[slot_s][31:0];
            illegal_s = csr_we_i;
        end else if (csr_addr_i == CSR_CYCLEH || csr_addr_i == CSR_INSTRETH) begin
            hit_s     = 1'b1;
            rdata_s   = cnt_val_s[slot_s][63:32];
            illegal_s = csr_we_i;
        end else begin
            hit_s = 1'b0;
        end
    end

    assign csr_rdata_o   = rdata_s;
    assign csr_hit_o     = hit_s;
    assign csr_illegal_o = illegal_s;

    // Strobes for slot 1 and unimplemented slots have no consumer.
    assign unused_s = ^{inc_s, we_lo_s, we_hi_s, we_evt_s};

    cve2_hpm_counter_unit_chk u_chk (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .csr_re_i      (csr_re_i),
        .csr_we_i      (csr_we_i),
        .csr_hit_i     (hit_s),
        .csr_illegal_i (illegal_s),
        .csr_rdata_i   (rdata_s)
    );

endmodule
